// File: rtl/hamming_seq_ctrl.sv
// Run sequencer for two Hamming(11,7) words: capture, encode, inject, check, correct, report.
// Start comes from a debounced active-low button; statistics counters saturate.
module hamming_seq_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_n,
   input  logic [13:0]      sw,
   input  logic [3:0]       err_pos0,
   input  logic [3:0]       err_pos1,
   output logic             busy,
   output logic             done,
   output logic [13:0]      data_out,
   output logic [3:0]       syn0,
   output logic [3:0]       syn1,
   output logic [1:0]       corrected,
   output logic [1:0]       uncorr,
   output logic             match,
   output logic [CNT_W-1:0] run_cnt,
   output logic [CNT_W-1:0] fix_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ENCODE, S_INJECT, S_CHECK, S_CORRECT, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   match_q, match_d;
   logic [CNT_W-1:0]       run_q, run_d, fix_q, fix_d, fail_q, fail_d;
   logic                   start_det;

   logic [1:0][3:0] err_pos_w;
   logic [1:0][6:0] dat_w;
   logic [1:0][6:0] dout_w;
   logic [1:0][6:0] dout_nx;
   logic [1:0][3:0] syn_w;
   logic [1:0]      corr_w, corr_nx, unc_w;

   assign err_pos_w = {err_pos1, err_pos0};

   // Data d0..d6 sit at positions 3,5,6,7,9,10,11; position p is bit p-1.
   function automatic logic [10:0] hm_encode(input logic [6:0] d);
      logic [10:0] c;
      c     = '0;
      c[2]  = d[0];
      c[4]  = d[1];
      c[5]  = d[2];
      c[6]  = d[3];
      c[8]  = d[4];
      c[9]  = d[5];
      c[10] = d[6];
      c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      c[3]  = d[1] ^ d[2] ^ d[3];
      c[7]  = d[4] ^ d[5] ^ d[6];
      return c;
   endfunction

   function automatic logic [3:0] hm_syndrome(input logic [10:0] c);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < 11; i++) begin
         if (c[i]) s = s ^ 4'(i + 1);
      end
      return s;
   endfunction

   function automatic logic [6:0] hm_extract(input logic [10:0] c);
      return {c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_word
         logic [6:0]  dat_q, dat_d;
         logic [3:0]  pos_q, pos_d;
         logic [10:0] cw_q, cw_d;
         logic [3:0]  syn_q, syn_d;
         logic [6:0]  dout_q, dout_d;
         logic        corr_q, corr_d, unc_q, unc_d;
         logic [10:0] fixed;

         always_comb begin
            dat_d  = dat_q;
            pos_d  = pos_q;
            cw_d   = cw_q;
            syn_d  = syn_q;
            dout_d = dout_q;
            corr_d = corr_q;
            unc_d  = unc_q;
            fixed  = cw_q;
            case (state_q)
               S_LOAD: begin
                  dat_d = sw[7*gi +: 7];
                  pos_d = err_pos_w[gi];
               end
               S_ENCODE: cw_d = hm_encode(dat_q);
               S_INJECT: begin
                  for (int i = 0; i < 11; i++) begin
                     if (pos_q == 4'(i + 1)) cw_d[i] = ~cw_q[i];
                  end
               end
               S_CHECK: syn_d = hm_syndrome(cw_q);
               S_CORRECT: begin
                  for (int i = 0; i < 11; i++) begin
                     if (syn_q == 4'(i + 1)) fixed[i] = ~cw_q[i];
                  end
                  corr_d = (syn_q != 4'd0) && (syn_q <= 4'd11);
                  unc_d  = (syn_q >= 4'd12);
                  dout_d = hm_extract(fixed);
               end
               default: ;
            endcase
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dat_q  <= '0;
               pos_q  <= '0;
               cw_q   <= '0;
               syn_q  <= '0;
               dout_q <= '0;
               corr_q <= 1'b0;
               unc_q  <= 1'b0;
            end else begin
               dat_q  <= dat_d;
               pos_q  <= pos_d;
               cw_q   <= cw_d;
               syn_q  <= syn_d;
               dout_q <= dout_d;
               corr_q <= corr_d;
               unc_q  <= unc_d;
            end
         end

         assign dat_w[gi]   = dat_q;
         assign dout_w[gi]  = dout_q;
         assign dout_nx[gi] = dout_d;
         assign syn_w[gi]   = syn_q;
         assign corr_w[gi]  = corr_q;
         assign corr_nx[gi] = corr_d;
         assign unc_w[gi]   = unc_q;
      end
   endgenerate

   assign start_det = prev_q & ~sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      sync_d  = {sync_q[SYNC_STAGES-2:0], start_n};
      prev_d  = sync_q[SYNC_STAGES-1];
      match_d = match_q;
      run_d   = run_q;
      fix_d   = fix_q;
      fail_d  = fail_q;
      case (state_q)
         S_IDLE:    if (start_det) state_d = S_LOAD;
         S_LOAD:    state_d = S_ENCODE;
         S_ENCODE:  state_d = S_INJECT;
         S_INJECT:  state_d = S_CHECK;
         S_CHECK:   state_d = S_CORRECT;
         S_CORRECT: begin
            state_d = S_DONE;
            match_d = ({dout_nx[1], dout_nx[0]} == {dat_w[1], dat_w[0]});
            // Counters are bumped on entry to DONE so they are current while done pulses.
            run_d   = sat_inc(run_q);
            if (|corr_nx) fix_d = sat_inc(fix_q);
            if (!match_d) fail_d = sat_inc(fail_q);
         end
         S_DONE:    state_d = start_det ? S_LOAD : S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sync_q  <= '1;
         prev_q  <= 1'b1;
         match_q <= 1'b0;
         run_q   <= '0;
         fix_q   <= '0;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         match_q <= match_d;
         run_q   <= run_d;
         fix_q   <= fix_d;
         fail_q  <= fail_d;
      end
   end

   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign data_out  = {dout_w[1], dout_w[0]};
   assign syn0      = syn_w[0];
   assign syn1      = syn_w[1];
   assign corrected = corr_w;
   assign uncorr    = unc_w;
   assign match     = match_q;
   assign run_cnt   = run_q;
   assign fix_cnt   = fix_q;
   assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Directed plus randomized runs of hamming_seq_ctrl checked against a position-array Hamming model.
module tb_hamming_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_n;
   logic [13:0] sw;
   logic [3:0]  err_pos0, err_pos1;
   logic        busy, done, match;
   logic [13:0] data_out;
   logic [3:0]  syn0, syn1;
   logic [1:0]  corrected, uncorr;
   logic [7:0]  run_cnt, fix_cnt, fail_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   int exp_run  = 0;
   int exp_fix  = 0;
   int exp_fail = 0;

   always #5 clk = ~clk;

   hamming_seq_ctrl #(.SYNC_STAGES(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start_n(start_n), .sw(sw),
      .err_pos0(err_pos0), .err_pos1(err_pos1),
      .busy(busy), .done(done), .data_out(data_out),
      .syn0(syn0), .syn1(syn1), .corrected(corrected), .uncorr(uncorr),
      .match(match), .run_cnt(run_cnt), .fix_cnt(fix_cnt), .fail_cnt(fail_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural codeword: array indexed by Hamming position 1..11.
   task automatic model_word(input logic [6:0] d, input int e, output logic [3:0] syn,
                             output logic [6:0] dout, output logic corr, output logic unc);
      int dp[7];
      bit b[12];
      int s;
      dp = '{3, 5, 6, 7, 9, 10, 11};
      for (int p = 0; p < 12; p++) b[p] = 1'b0;
      for (int k = 0; k < 7; k++) b[dp[k]] = d[k];
      b[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      b[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      b[4] = d[1] ^ d[2] ^ d[3];
      b[8] = d[4] ^ d[5] ^ d[6];
      if (e >= 1 && e <= 11) b[e] = !b[e];
      s = 0;
      for (int p = 1; p <= 11; p++) if (b[p]) s = s ^ p;
      corr = 1'b0;
      unc  = 1'b0;
      if (s >= 1 && s <= 11) begin
         b[s] = !b[s];
         corr = 1'b1;
      end else if (s >= 12) begin
         unc = 1'b1;
      end
      syn = 4'(s);
      for (int k = 0; k < 7; k++) dout[k] = b[dp[k]];
   endtask

   task automatic run(input logic [13:0] s, input logic [3:0] e0, input logic [3:0] e1,
                      input bit glitch, input bit full);
      logic [3:0] es0, es1;
      logic [6:0] ed0, ed1;
      logic       c0, c1, u0, u1, em;
      int         dones, lat;
      model_word(s[6:0], int'(e0), es0, ed0, c0, u0);
      model_word(s[13:7], int'(e1), es1, ed1, c1, u1);
      em = ({ed1, ed0} == s);
      @(negedge clk);
      sw = s; err_pos0 = e0; err_pos1 = e1; start_n = 1'b0;
      dones = 0; lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) start_n = 1'b1;
         if (glitch && c == 3) start_n = 1'b0;
         if (glitch && c == 5) start_n = 1'b1;
         if (full && c == 3) check("busy_after_start", busy, 1);
         if (done) begin
            dones++;
            if (lat == 0) lat = c;
         end
      end
      exp_run = (exp_run < 255) ? exp_run + 1 : 255;
      if ((c0 | c1) && exp_fix < 255) exp_fix++;
      if (!em && exp_fail < 255) exp_fail++;
      $display("run sw=%h e0=%0d e1=%0d glitch=%0d -> data=%h syn=%0d/%0d corr=%b unc=%b match=%0d runs=%0d lat=%0d",
               s, e0, e1, glitch, data_out, syn0, syn1, corrected, uncorr, match, run_cnt, lat);
      check("run_cnt", run_cnt, exp_run);
      check("data_out", data_out, {ed1, ed0});
      check("corrected", corrected, {c1, c0});
      if (full) begin
         check("done_count", dones, 1);
         check("latency", lat, 8);
         check("syn0", syn0, es0);
         check("syn1", syn1, es1);
         check("uncorr", uncorr, {u1, u0});
         check("match", match, em);
         check("fix_cnt", fix_cnt, exp_fix);
         check("fail_cnt", fail_cnt, exp_fail);
         check("idle_busy", busy, 0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_data"}, data_out, 0);
      check({tag, "_syn"}, {syn1, syn0}, 0);
      check({tag, "_flags"}, {corrected, uncorr, match}, 0);
      check({tag, "_cnts"}, {run_cnt, fix_cnt, fail_cnt}, 0);
   endtask

   initial begin
      rst_n = 1'b0; start_n = 1'b1; sw = '0; err_pos0 = '0; err_pos1 = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run(14'h2A55, 4'd0,  4'd0,  1'b0, 1'b1);
      run(14'h1234, 4'd5,  4'd11, 1'b0, 1'b1);
      check("t2_syn", {syn1, syn0}, {4'd11, 4'd5});
      run(14'h3FFF, 4'd3,  4'd0,  1'b0, 1'b1);
      run(14'h0000, 4'd12, 4'd15, 1'b0, 1'b1);
      run(14'h0ABC, 4'd1,  4'd8,  1'b1, 1'b1);

      // Reset while the run is in CHECK.
      @(negedge clk);
      sw = 14'h1555; err_pos0 = 4'd2; err_pos1 = 4'd9; start_n = 1'b0;
      @(negedge clk);
      start_n = 1'b1;
      repeat (5) @(negedge clk);
      check("abort_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("abort");
      exp_run = 0; exp_fix = 0; exp_fail = 0;
      @(negedge clk);
      rst_n = 1'b1;
      run(14'h1555, 4'd2, 4'd9, 1'b0, 1'b1);

      for (int i = 0; i < 20; i++)
         run(14'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b1);

      for (int i = 0; i < 259; i++)
         run(14'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      check("run_sat", run_cnt, 255);
      check("fix_cnt_end", fix_cnt, exp_fix);
      check("fail_cnt_end", fail_cnt, exp_fail);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
